imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: takes a boot frame (A5, N lo/hi, N little-endian words, XOR checksum) from a byte
// stream, writes the words to instruction memory and keeps the core in reset until the checksum matches.
// Latency: imem_we rises one cycle after the 4th byte of a word; rx_ready is tied to 1 (never stalls).
// Optional LOADER_TIMEOUT_EN: an inter-byte timeout forces ERR when a frame stalls mid-load.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [7:0] SYNC = 8'hA5;

  state_t      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [1:0]  bcnt_q;
  logic [23:0] word_q;     // bytes 0..2 of the word in flight; byte 3 comes straight from rx_data
  logic [7:0]  csum_q;
  logic        imem_we_q, core_rst_q, load_done_q, load_err_q;
  logic [31:0] imem_addr_q, imem_wdata_q;

  logic [15:0] len_d;
  logic [7:0]  csum_d;
  logic [31:0] addr_d;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        active;
  assign active = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CSUM);
`endif

  // Every byte is consumed; the upstream receiver has nowhere to hold it anyway.
  assign rx_ready = 1'b1;

  assign len_d  = {rx_data, len_q[7:0]};
  assign csum_d = csum_q ^ rx_data;
  assign addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

  // Frame parser: state, counters, checksum and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      // Timeout runs only mid-frame and restarts on every accepted byte.
      if (!active || rx_valid) begin
        tmo_q <= '0;
      end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
        tmo_q      <= '0;
        state_q    <= ERR;
        load_err_q <= 1'b1;
        core_rst_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 32'd1;
      end
`endif
      if (rx_valid) begin
        case (state_q)
          IDLE, DONE, ERR: begin
            // Only a sync byte starts a frame; anything else is noise on the line.
            if (rx_data == SYNC) begin
              state_q     <= LEN0;
              csum_q      <= '0;
              bcnt_q      <= '0;
              idx_q       <= '0;
              load_done_q <= 1'b0;
              load_err_q  <= 1'b0;
              core_rst_q  <= 1'b1;
            end
          end
          LEN0: begin
            len_q[7:0] <= rx_data;
            csum_q     <= csum_d;
            state_q    <= LEN1;
          end
          LEN1: begin
            len_q[15:8] <= rx_data;
            csum_q      <= csum_d;
            if (32'(len_d) > MAX_WORDS) begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            csum_q <= csum_d;
            bcnt_q <= bcnt_q + 2'd1;
            case (bcnt_q)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_wdata_q <= {rx_data, word_q};
                imem_addr_q  <= addr_d;
                idx_q        <= idx_q + 16'd1;
                if (idx_q == len_q - 16'd1) state_q <= CSUM;
              end
            endcase
          end
          CSUM: begin
            if (rx_data == csum_q) begin
              state_q     <= DONE;
              core_rst_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
